// File: rtl/mdio_pkg.sv
// Purpose : shared types and constants for the MDIO management master.
// Latency : n/a (package only).
// Backpres: n/a. Holds FSM states, ST/OP codes, frame field offsets and phase lengths.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_TA,
    S_DATA,
    S_DONE
  } mdio_state_t;

  // Start-of-frame codes
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  // Opcodes
  localparam logic [1:0] OP_C22_WR   = 2'b01;
  localparam logic [1:0] OP_C22_RD   = 2'b10;
  localparam logic [1:0] OP_C45_ADDR = 2'b00;
  localparam logic [1:0] OP_C45_WR   = 2'b01;
  localparam logic [1:0] OP_C45_PRD  = 2'b10;
  localparam logic [1:0] OP_C45_RD   = 2'b11;

  // Frame field offsets (MSB first on the wire)
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int PHYAD_LSB = 23;
  localparam int REGAD_MSB = 22;
  localparam int REGAD_LSB = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // Phase lengths in MDC bits, stored as last index
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  // A frame is read-type if the PHY drives TA/DATA back to us.
  function automatic logic f_is_read(input logic [1:0] st, input logic [1:0] op);
    if (st == ST_C22) return (op == OP_C22_RD);
    return (op == OP_C45_RD) || (op == OP_C45_PRD);
  endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// Purpose : MDC generator; DIV clk cycles low then DIV cycles high, with one-cycle
//           rise/fall strobes asserted in the clk cycle whose closing edge moves MDC.
// Latency : MDC starts low on the first enabled cycle. Backpres: none; held at 0 while i_en=0.
// Ports   : clk, rst_n (async active-low), i_en, o_mdc, o_mdc_rise, o_mdc_fall.
module mdio_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_mdc,
  output logic o_mdc_rise,
  output logic o_mdc_fall
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] r_cnt;
  logic       r_mdc;
  logic       w_wrap;

  assign w_wrap     = i_en && (r_cnt == LAST);
  assign o_mdc      = r_mdc;
  assign o_mdc_rise = w_wrap && !r_mdc;
  assign o_mdc_fall = w_wrap &&  r_mdc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
      r_mdc <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= 8'd0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= 8'd0;
      r_mdc <= !r_mdc;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Purpose : IEEE 802.3 MDIO master; serialises a 32-bit frame behind a configurable preamble,
//           drives/releases the pad, captures read data and checks the PHY turnaround bit.
// Latency : (PRE_LEN+32)*2*MDC_DIV clk from first PREAMBLE cycle to DONE; BUSY from the cycle after START.
// Backpres: MDIO_START is ignored while BUSY; illegal frames give a one-cycle ERR, no MDC activity.
// Build   : define MDIO_CL45_EN to accept ST=00 (Clause 45) frames; otherwise they raise ERR.
// Ports   : clk, reset (async active-low), MDIO_START, T_DATA[31:0], MDIO_IN -> MDC, MDIO_OUT,
//           MDIO_OE, RD_DATA[15:0], DATA_RDY, BUSY, ERR, BIT_CNT[5:0].
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int MDC_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY,
  output logic        ERR,
  output logic [5:0]  BIT_CNT
);

  localparam logic [5:0] PRE_LAST = (PRE_LEN == 0) ? 6'd0 : 6'(PRE_LEN - 1);

  mdio_state_t r_state, w_state_nxt;
  logic [5:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [31:0] r_shadow;
  logic        r_is_read;
  logic        r_ta_err;
  logic [15:0] r_rx;
  logic [15:0] r_rd_data;
  logic        r_mdio_out, w_mdio_out_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_data_rdy, w_data_rdy_nxt;
  logic        r_err, w_err_nxt;

  logic        w_clk_en, w_mdc_rise, w_mdc_fall;
  logic [1:0]  w_st, w_op;
  logic        w_legal, w_start_read, w_rd_nxt;
  logic [31:0] w_src;

  assign w_st         = T_DATA[ST_MSB:ST_LSB];
  assign w_op         = T_DATA[OP_MSB:OP_LSB];
  assign w_start_read = f_is_read(w_st, w_op);

`ifdef MDIO_CL45_EN
  assign w_legal = ((w_st == ST_C22) && ((w_op == OP_C22_WR) || (w_op == OP_C22_RD)))
                || (w_st == ST_C45);
`else
  assign w_legal = (w_st == ST_C22) && ((w_op == OP_C22_WR) || (w_op == OP_C22_RD));
`endif

  assign w_clk_en = (r_state == S_PREAMBLE) || (r_state == S_HEADER) ||
                    (r_state == S_TA)       || (r_state == S_DATA);

  mdio_clk_div #(.DIV(MDC_DIV)) u_clk_div (
    .clk        (clk),
    .rst_n      (reset),
    .i_en       (w_clk_en),
    .o_mdc      (MDC),
    .o_mdc_rise (w_mdc_rise),
    .o_mdc_fall (w_mdc_fall)
  );

  // Next-state: every phase advances on the MDC falling strobe.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_data_rdy_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MDIO_START) begin
          if (w_legal) begin
            w_state_nxt   = (PRE_LEN == 0) ? S_HEADER : S_PREAMBLE;
            w_bit_cnt_nxt = 6'd0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (w_mdc_fall) begin
          if (r_bit_cnt == PRE_LAST) begin
            w_state_nxt   = S_HEADER;
            w_bit_cnt_nxt = 6'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
      end
      S_HEADER: begin
        if (w_mdc_fall) begin
          if (r_bit_cnt == HDR_LAST) begin
            w_state_nxt   = S_TA;
            w_bit_cnt_nxt = 6'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
      end
      S_TA: begin
        if (w_mdc_fall) begin
          if (r_bit_cnt == TA_LAST) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = 6'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
      end
      S_DATA: begin
        if (w_mdc_fall) begin
          if (r_bit_cnt == DATA_LAST) begin
            w_state_nxt    = S_DONE;
            w_bit_cnt_nxt  = 6'd0;
            w_data_rdy_nxt = r_is_read;
            w_err_nxt      = r_is_read && r_ta_err;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 6'd1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = 6'd0;
      end
    endcase
  end

  // Pad outputs follow the next state, so they only move together with a state/count step
  // (frame entry or an MDC fall). At frame entry the shadow is not loaded yet: use T_DATA.
  assign w_src    = (r_state == S_IDLE) ? T_DATA : r_shadow;
  assign w_rd_nxt = (r_state == S_IDLE) ? w_start_read : r_is_read;

  always_comb begin
    w_oe_nxt       = 1'b0;
    w_mdio_out_nxt = 1'b0;
    case (w_state_nxt)
      S_PREAMBLE: begin
        w_oe_nxt       = 1'b1;
        w_mdio_out_nxt = 1'b1;
      end
      S_HEADER: begin
        w_oe_nxt       = 1'b1;
        w_mdio_out_nxt = w_src[5'd31 - w_bit_cnt_nxt[4:0]];
      end
      S_TA: begin
        // Write turnaround is always 1 then 0; reads release the pad.
        w_oe_nxt       = !w_rd_nxt;
        w_mdio_out_nxt = !w_rd_nxt && !w_bit_cnt_nxt[0];
      end
      S_DATA: begin
        w_oe_nxt       = !w_rd_nxt;
        w_mdio_out_nxt = !w_rd_nxt && w_src[5'd15 - w_bit_cnt_nxt[4:0]];
      end
      default: begin
        w_oe_nxt       = 1'b0;
        w_mdio_out_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 6'd0;
      r_shadow   <= 32'd0;
      r_is_read  <= 1'b0;
      r_ta_err   <= 1'b0;
      r_rx       <= 16'd0;
      r_rd_data  <= 16'd0;
      r_mdio_out <= 1'b0;
      r_oe       <= 1'b0;
      r_data_rdy <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_mdio_out <= w_mdio_out_nxt;
      r_oe       <= w_oe_nxt;
      r_data_rdy <= w_data_rdy_nxt;
      r_err      <= w_err_nxt;
      if ((r_state == S_IDLE) && MDIO_START && w_legal) begin
        r_shadow  <= T_DATA;
        r_is_read <= w_start_read;
        r_ta_err  <= 1'b0;
      end
      // PHY data is sampled as MDC rises; only the second TA bit is checked.
      if (w_mdc_rise && r_is_read) begin
        if ((r_state == S_TA) && r_bit_cnt[0]) r_ta_err <= MDIO_IN;
        if (r_state == S_DATA) r_rx <= {r_rx[14:0], MDIO_IN};
      end
      // The last sample lands on the rise before the final fall, so r_rx is complete here.
      if (w_data_rdy_nxt) r_rd_data <= r_rx;
    end
  end

  assign MDIO_OUT = r_mdio_out;
  assign MDIO_OE  = r_oe;
  assign RD_DATA  = r_rd_data;
  assign DATA_RDY = r_data_rdy;
  assign ERR      = r_err;
  assign BUSY     = (r_state != S_IDLE);
  assign BIT_CNT  = r_bit_cnt;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Bench for mdio_master_ctrl: two instances (defaults, and MDC_DIV=2/PRE_LEN=0) driven with
// directed and random frames; expected waveforms come from frame arithmetic and a PHY model.
module tb_mdio_master_ctrl;

`ifdef MDIO_CL45_EN
  localparam bit CL45 = 1'b1;
`else
  localparam bit CL45 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]        start;
  logic [1:0]        min;
  logic [1:0][31:0]  td;
  logic [1:0]        mdc, mout, moe, rdy, busy, err;
  logic [1:0][15:0]  rdd;
  logic [1:0][5:0]   bcnt;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] last_rd [2];

  mdio_master_ctrl #(.MDC_DIV(4), .PRE_LEN(32)) u_dut0 (
    .clk(clk), .reset(rst_n), .MDIO_START(start[0]), .T_DATA(td[0]), .MDIO_IN(min[0]),
    .MDC(mdc[0]), .MDIO_OUT(mout[0]), .MDIO_OE(moe[0]), .RD_DATA(rdd[0]),
    .DATA_RDY(rdy[0]), .BUSY(busy[0]), .ERR(err[0]), .BIT_CNT(bcnt[0])
  );

  mdio_master_ctrl #(.MDC_DIV(2), .PRE_LEN(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .MDIO_START(start[1]), .T_DATA(td[1]), .MDIO_IN(min[1]),
    .MDC(mdc[1]), .MDIO_OUT(mout[1]), .MDIO_OE(moe[1]), .RD_DATA(rdd[1]),
    .DATA_RDY(rdy[1]), .BUSY(busy[1]), .ERR(err[1]), .BIT_CNT(bcnt[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int f_div(input int s);
    return (s == 0) ? 4 : 2;
  endfunction

  function automatic int f_pre(input int s);
    return (s == 0) ? 32 : 0;
  endfunction

  function automatic bit f_legal(input logic [31:0] t);
    if (t[31:30] == 2'b01) return (t[29:28] == 2'b01) || (t[29:28] == 2'b10);
    if (t[31:30] == 2'b00) return CL45;
    return 1'b0;
  endfunction

  function automatic bit f_read(input logic [31:0] t);
    if (t[31:30] == 2'b01) return (t[29:28] == 2'b10);
    return t[29];
  endfunction

  // Expected wire bit b of a write-style frame.
  function automatic logic f_bit(input int b, input int pre, input logic [31:0] t);
    if (b < pre) return 1'b1;
    if (b < pre + 14) return t[31 - (b - pre)];
    if (b == pre + 14) return 1'b1;
    if (b == pre + 15) return 1'b0;
    return t[15 - (b - pre - 16)];
  endfunction

  function automatic int f_pidx(input int b, input int pre);
    if (b < pre) return b;
    if (b < pre + 14) return b - pre;
    if (b < pre + 16) return b - pre - 14;
    return b - pre - 16;
  endfunction

  // PHY: what it presents for the r-th MDC rise (pull-up when not driving).
  function automatic logic f_phy(input int r, input int pre, input logic [15:0] d, input logic ta1, input bit rd);
    if (rd && r == pre + 15) return ta1;
    if (rd && r >= pre + 16 && r < pre + 32) return d[15 - (r - pre - 16)];
    return 1'b1;
  endfunction

  task automatic run_frame(input int sel, input logic [31:0] t, input logic [15:0] phy,
                           input logic ta1, input int abort_bit, input bit poke);
    int d, pre, n, abort_k, poke_k, rises, b, ph, rdy_k, err_k;
    int bad_mdc, bad_busy, bad_oe, bad_out, bad_bcnt, n_rdy, n_err;
    bit rd;
    logic e_mdc, e_busy, e_oe, prev_mdc;
    logic [15:0] rd_at_done;
    d = f_div(sel); pre = f_pre(sel); n = (pre + 32) * 2 * d; rd = f_read(t);
    abort_k = (abort_bit >= 0) ? abort_bit * 2 * d + 1 : -1;
    poke_k  = poke ? int'($urandom_range(n - 1, 1)) : -1;
    rises = 0; rdy_k = -1; err_k = -1; prev_mdc = 1'b0; rd_at_done = 16'h0;
    bad_mdc = 0; bad_busy = 0; bad_oe = 0; bad_out = 0; bad_bcnt = 0; n_rdy = 0; n_err = 0;
    td[sel] = t; min[sel] = 1'b1; start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_mdc", mdc[sel], 1'b0);
        check("abort_oe", moe[sel], 1'b0);
        check("abort_busy", busy[sel], 1'b0);
        check("abort_misc", {mout[sel], rdy[sel], err[sel], rdd[sel], bcnt[sel]}, 0);
        min[sel] = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        @(posedge clk); #1;
        return;
      end
      if (k < n) begin
        b = k / (2 * d); ph = k % (2 * d);
        e_mdc = (ph >= d); e_busy = 1'b1; e_oe = (b < pre + 14) || !rd;
        if (e_oe && mout[sel] !== f_bit(b, pre, t)) bad_out++;
        if (bcnt[sel] !== 6'(f_pidx(b, pre))) bad_bcnt++;
      end else begin
        e_mdc = 1'b0; e_busy = (k == n); e_oe = 1'b0;
      end
      if (mdc[sel] !== e_mdc) bad_mdc++;
      if (busy[sel] !== e_busy) bad_busy++;
      if (moe[sel] !== e_oe) bad_oe++;
      if (rdy[sel] === 1'b1) begin n_rdy++; rdy_k = k; end
      if (err[sel] === 1'b1) begin n_err++; err_k = k; end
      if (k == n) rd_at_done = rdd[sel];
      if (!prev_mdc && mdc[sel] === 1'b1) rises++;
      prev_mdc = mdc[sel];
      min[sel] = f_phy(rises, pre, phy, ta1, rd);
      if (k == poke_k) begin
        start[sel] = 1'b1; td[sel] = $urandom;
      end else begin
        start[sel] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start[sel] = 1'b0; min[sel] = 1'b1;
    check("mdc_wave", bad_mdc, 0);
    check("busy_wave", bad_busy, 0);
    check("oe_wave", bad_oe, 0);
    check("out_bits", bad_out, 0);
    check("bit_cnt", bad_bcnt, 0);
    check("rdy_count", n_rdy, rd ? 1 : 0);
    check("err_count", n_err, (rd && ta1) ? 1 : 0);
    if (rd) check("rdy_at_done", rdy_k, n);
    if (rd && ta1) check("err_at_done", err_k, n);
    check("rd_data", rd_at_done, rd ? phy : last_rd[sel]);
    if (rd) last_rd[sel] = phy;
  endtask

  task automatic run_illegal(input int sel, input logic [31:0] t);
    int n_mdc, n_err, n_busy;
    n_mdc = 0; n_err = 0; n_busy = 0;
    td[sel] = t; start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    check("ill_err", err[sel], 1'b1);
    check("ill_busy", busy[sel], 1'b0);
    for (int k = 0; k < 8 * f_div(sel); k++) begin
      @(posedge clk); #1;
      if (mdc[sel] === 1'b1) n_mdc++;
      if (err[sel] === 1'b1) n_err++;
      if (busy[sel] === 1'b1) n_busy++;
    end
    check("ill_mdc", n_mdc, 0);
    check("ill_err_len", n_err, 0);
    check("ill_busy_len", n_busy, 0);
  endtask

  task automatic run(input int sel, input logic [31:0] t, input logic [15:0] phy,
                     input logic ta1, input bit poke);
    if (f_legal(t)) run_frame(sel, t, phy, ta1, -1, poke);
    else run_illegal(sel, t);
  endtask

  initial begin
    logic [31:0] t;
    start = '0; min = '1; td = '0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_outs", {mdc[s], mout[s], moe[s], rdy[s], busy[s], err[s]}, 0);
      check("rst_rd", rdd[s], 16'h0);
      check("rst_bcnt", bcnt[s], 6'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed, default instance
    run(0, 32'h5192ABCD, 16'h0000, 1'b0, 1'b0);
    run(0, 32'h61920000, 16'h1234, 1'b0, 1'b0);
    run(0, 32'h61920000, 16'hFFFF, 1'b1, 1'b0);
    run(0, 32'h5192ABCD, 16'h0000, 1'b0, 1'b0);
    run(0, 32'h0192ABCD, 16'h0000, 1'b0, 1'b0);
    run(0, 32'h31920000, 16'hBEEF, 1'b0, 1'b0);
    run(0, 32'hC192ABCD, 16'h0000, 1'b0, 1'b0);
    run(0, 32'h8192ABCD, 16'h0000, 1'b0, 1'b0);
    run(0, 32'h4192ABCD, 16'h0000, 1'b0, 1'b0);
    run(0, 32'h7192ABCD, 16'h0000, 1'b0, 1'b0);

    // Short instance with START pokes mid-frame
    run(1, 32'h5192ABCD, 16'h0000, 1'b0, 1'b1);
    run(1, 32'h61920000, 16'h1234, 1'b0, 1'b1);
    run(1, 32'h21925555, 16'hC3A5, 1'b0, 1'b1);

    // Reset at bit 40 of a write, then a clean frame
    run_frame(0, 32'h5192ABCD, 16'h0000, 1'b0, 40, 1'b0);
    run(0, 32'h5192ABCD, 16'h0000, 1'b0, 1'b0);

    // Random frames, mostly legal Clause 22
    for (int i = 0; i < 12; i++) begin
      int s;
      s = i % 2;
      t = $urandom;
      if ($urandom_range(3, 0) != 0) begin
        t[31:30] = 2'b01;
        t[29:28] = ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
      end
      run(s, t, 16'($urandom), ($urandom_range(3, 0) == 0), (s == 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdio_master_ctrl.md
# mdio_master_ctrl

Parametrised IEEE 802.3 MDIO management master, the next generation of the team's MDIO generator. It accepts a 32-bit management frame on a start strobe and generates MDC from the system clock through a programmable divider. It serialises the frame with a configurable preamble, captures read data from the PHY and checks the turnaround bit. Clause 45 framing is optional at compile time. It sits between the register/host side and the PHY-facing MDIO pad (tri-state buffer external, controlled by MDIO_OE).

## Interface
- MDC_DIV, 4: clk cycles per MDC half-period; legal range 2..255.
- PRE_LEN, 32: preamble length in MDC bits; legal range 0..32 (0 = preamble suppression).
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- MDIO_START  input  1  one-cycle request; sampled only in IDLE.
- T_DATA  input  32  frame, MSB first: ST[31:30] OP[29:28] PHYAD[27:23] REGAD[22:18] TA[17:16] DATA[15:0].
- MDIO_IN  input  1  MDIO pad input.
- MDC  output  1  management clock.
- MDIO_OUT  output  1  MDIO pad output value.
- MDIO_OE  output  1  pad output enable (1 = master drives).
- RD_DATA  output  16  captured read data.
- DATA_RDY  output  1  one-cycle completion pulse for reads.
- BUSY  output  1  frame in progress.
- ERR  output  1  one-cycle error pulse (illegal frame or missing PHY).
- BIT_CNT  output  6  bit index within the current phase, for debug.

## Operation
- States: IDLE, PREAMBLE, HEADER (ST, OP, PHYAD, REGAD: 14 bits), TA (2 bits), DATA (16 bits), DONE.
- IDLE: MDC=0, MDIO_OE=0, BUSY=0. MDIO_START=1 latches T_DATA into a shadow register and enters PREAMBLE (HEADER if PRE_LEN=0). BUSY=1 from the next cycle.
- Each MDC bit period is MDC_DIV clk cycles low, then MDC_DIV cycles high.
- MDIO_OUT changes only on the clk cycle in which MDC falls (or at frame entry). MDIO_IN is sampled on the clk cycle in which MDC rises.
- PREAMBLE: PRE_LEN bits of 1, MDIO_OE=1.
- HEADER: 14 shadow bits MSB first, MDIO_OE=1.
- Frame classification:
  - Write-type: Clause 22 OP=01; Clause 45 OP=00 (address) and OP=01 (write). TA drives 1,0, then DATA drives 16 bits. MDIO_OE=1 throughout.
  - Read-type: Clause 22 OP=10; Clause 45 OP=11 (read) and OP=10 (post-read-increment read). MDIO_OE=0 from the falling MDC edge that starts TA until the end of the frame.
- Read frames: the second TA bit must sample 0; a 1 flags a missing PHY. DATA then shifts 16 samples MSB first into RD_DATA.
- DONE: lasts one clk cycle. MDC=0 and MDIO_OE=0. DATA_RDY=1 for reads. ERR=1 if the TA check failed. BUSY falls on the following cycle.
- Illegal frames (ST=11, ST=10, Clause 22 OP=00/11, or ST=00 with Clause 45 disabled): a one-cycle ERR pulse the cycle after START. Return to IDLE with no MDC activity.
- MDIO_START while BUSY is ignored.
- Reset asserted mid-frame forces IDLE immediately. All outputs return to reset values.
- Reset values: MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=16'h0000, DATA_RDY=0, BUSY=0, ERR=0, BIT_CNT=0.

## Timing
- Frame length: (PRE_LEN+32) × 2 × MDC_DIV clk cycles from the first cycle in PREAMBLE to DONE. Defaults give 512 cycles.
- RD_DATA is stable from the DONE cycle until the next read's DONE.
- DATA_RDY and ERR are exactly one clk cycle wide. Both may assert together on a TA failure.
- Minimum START-to-START spacing: frame length + 2 cycles.

## Configuration
- MDIO_CL45_EN defined: ST=00 frames are accepted and decoded as Clause 45 (OP 00 address, 01 write, 10 post-read-increment read, 11 read).
- MDIO_CL45_EN undefined: only ST=01 is legal; ST=00 frames raise ERR.

## Structure
- Shared package mdio_pkg holds:
  - the state enum;
  - ST codes ST_C22=2'b01 and ST_C45=2'b00;
  - OP codes;
  - T_DATA field offsets.
- One sub-module, mdio_clk_div: divider counter producing MDC plus one-cycle mdc_rise/mdc_fall strobes, enabled only while BUSY.

## Test plan
- C22 write, T_DATA=32'h5192ABCD, defaults: 32 preamble 1s, then 01 01 00011 00100 10 16'hABCD on MDIO_OUT. MDIO_OE=1 throughout. BUSY for 512 cycles, no DATA_RDY.
- C22 read, T_DATA=32'h61920000, PHY drives TA 0 and data 16'h1234: MDIO_OE=0 from TA onward, RD_DATA=16'h1234, DATA_RDY one pulse, ERR=0.
- C22 read with MDIO_IN held 1: RD_DATA=16'hFFFF, DATA_RDY and ERR pulse together.
- T_DATA=32'h0192ABCD: with MDIO_CL45_EN, a full frame with ST=00. Without it, ERR the cycle after START and no MDC edges.
- PRE_LEN=0, MDC_DIV=2: frame is 128 cycles, HEADER starts immediately. START mid-frame is ignored.
- reset low at bit 40 of a write: MDC=0, MDIO_OE=0 and BUSY=0 asynchronously. Next START produces a complete frame.
